// File: rtl/ifu_prefetch_if.sv
// Signal bundle between the prefetching IFU and its neighbours:
// imem request/response, decode handoff and fetch-stream redirect.
interface ifu_prefetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        redirect_valid;
    logic [1:0]  redirect_mode;
    logic [31:0] redirect_pc;
    logic [15:0] redirect_imm16;
    logic [25:0] redirect_addr26;
    logic [31:0] redirect_target;

    modport master (
        output imem_req, imem_addr,
        input  imem_ready, imem_rvalid, imem_rdata,
        output instr_valid, instr, instr_pc,
        input  instr_ready,
        input  redirect_valid, redirect_mode, redirect_pc,
        input  redirect_imm16, redirect_addr26, redirect_target
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ready, imem_rvalid, imem_rdata,
        input  instr_valid, instr, instr_pc,
        output instr_ready,
        output redirect_valid, redirect_mode, redirect_pc,
        output redirect_imm16, redirect_addr26, redirect_target
    );
endinterface

// File: rtl/ifu_prefetch.sv
// Prefetching instruction fetch unit: in-order imem requests under a credit limit,
// instruction buffer towards decode, and redirects that drop stale in-flight words.
module ifu_prefetch #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR      = 32'h0000_0080,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input logic            clk,
    input logic            rst_n,
    ifu_prefetch_if.master bus
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned SQ_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic [31:0]      fetch_pc_r;
    logic [OUT_W-1:0] out_r;
    logic [OUT_W-1:0] out_next_s;
    logic [OUT_W-1:0] drop_r;
    logic [OUT_W-1:0] drop_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [31:0]      fifo_instr_r [FIFO_DEPTH];
    logic [31:0]      fifo_pc_r    [FIFO_DEPTH];
    logic [31:0]      sq_pc_r      [MAX_OUTSTANDING];
    logic [SQ_W-1:0]  sq_rd_r;
    logic [SQ_W-1:0]  sq_wr_r;
    logic             req_s;
    logic             accept_s;
    logic             push_s;
    logic             pop_s;
    logic [31:0]      occupancy_s;
    logic [31:0]      target_s;

    function automatic logic [31:0] redirect_target_f(
        input logic [1:0]  mode,
        input logic [31:0] pc,
        input logic [15:0] imm16,
        input logic [25:0] addr26,
        input logic [31:0] reg_target
    );
        logic [31:0] base;
        base = pc + 32'd4;
        case (mode)
            2'b00:   redirect_target_f = {base[31:28], addr26, 2'b00};
            2'b01:   redirect_target_f = base + {{14{imm16[15]}}, imm16, 2'b00};
            2'b10:   redirect_target_f = reg_target & ~32'h0000_0003;
            2'b11:   redirect_target_f = EXC_VECTOR;
            default: redirect_target_f = EXC_VECTOR;
        endcase
    endfunction

    // The PC side queue holds exactly the outstanding requests, so it wraps at MAX_OUTSTANDING.
    function automatic logic [SQ_W-1:0] sq_next_f(input logic [SQ_W-1:0] ptr);
        if (ptr == SQ_W'(MAX_OUTSTANDING - 1)) sq_next_f = {SQ_W{1'b0}};
        else                                   sq_next_f = ptr + SQ_W'(1);
    endfunction

    // Issue credit, handshake qualification and redirect target.
    always_comb begin
        occupancy_s = 32'(cnt_r) + 32'(out_r);
        req_s       = 1'b0;
        if (rst_n && !bus.redirect_valid && (32'(out_r) < MAX_OUTSTANDING) &&
            (occupancy_s < FIFO_DEPTH)) begin
            req_s = 1'b1;
        end else begin
            req_s = 1'b0;
        end
        accept_s = req_s & bus.imem_ready;
        pop_s    = (cnt_r != {CNT_W{1'b0}}) & bus.instr_ready & ~bus.redirect_valid;
        push_s   = bus.imem_rvalid & (drop_r == {OUT_W{1'b0}}) & ~bus.redirect_valid;
        target_s = redirect_target_f(bus.redirect_mode, bus.redirect_pc, bus.redirect_imm16,
                                     bus.redirect_addr26, bus.redirect_target);
    end

    // Next values of the outstanding, drop and buffer-occupancy counters.
    always_comb begin
        out_next_s  = out_r;
        drop_next_s = drop_r;
        cnt_next_s  = cnt_r;
        case ({accept_s, bus.imem_rvalid})
            2'b10:   out_next_s = out_r + OUT_W'(1);
            2'b01:   out_next_s = out_r - OUT_W'(1);
            default: out_next_s = out_r;
        endcase
        if (bus.redirect_valid) begin
            // No accept can happen here, so everything still in flight afterwards is stale.
            drop_next_s = out_next_s;
            cnt_next_s  = {CNT_W{1'b0}};
        end else begin
            if (bus.imem_rvalid && (drop_r != {OUT_W{1'b0}})) drop_next_s = drop_r - OUT_W'(1);
            else                                               drop_next_s = drop_r;
            case ({push_s, pop_s})
                2'b10:   cnt_next_s = cnt_r + CNT_W'(1);
                2'b01:   cnt_next_s = cnt_r - CNT_W'(1);
                default: cnt_next_s = cnt_r;
            endcase
        end
    end

    // Fetch PC, counters and buffer pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_r <= RESET_PC;
            out_r      <= {OUT_W{1'b0}};
            drop_r     <= {OUT_W{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            wr_ptr_r   <= {PTR_W{1'b0}};
        end else begin
            out_r  <= out_next_s;
            drop_r <= drop_next_s;
            cnt_r  <= cnt_next_s;
            if (bus.redirect_valid) begin
                fetch_pc_r <= target_s;
                rd_ptr_r   <= {PTR_W{1'b0}};
                wr_ptr_r   <= {PTR_W{1'b0}};
            end else begin
                if (accept_s) fetch_pc_r <= fetch_pc_r + 32'd4;
                else          fetch_pc_r <= fetch_pc_r;
                if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
                else        wr_ptr_r <= wr_ptr_r;
                if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_W'(1);
                else       rd_ptr_r <= rd_ptr_r;
            end
        end
    end

    // Instruction buffer storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_instr_r[i] <= 32'h0000_0000;
                fifo_pc_r[i]    <= 32'h0000_0000;
            end
        end else if (push_s) begin
            fifo_instr_r[wr_ptr_r] <= bus.imem_rdata;
            fifo_pc_r[wr_ptr_r]    <= sq_pc_r[sq_rd_r];
        end
    end

    // PC side queue: request address on accept, released by the matching response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) sq_pc_r[i] <= 32'h0000_0000;
            sq_rd_r <= {SQ_W{1'b0}};
            sq_wr_r <= {SQ_W{1'b0}};
        end else begin
            if (accept_s) begin
                sq_pc_r[sq_wr_r] <= fetch_pc_r;
                sq_wr_r          <= sq_next_f(sq_wr_r);
            end
            if (bus.imem_rvalid) sq_rd_r <= sq_next_f(sq_rd_r);
        end
    end

    assign bus.imem_req    = req_s;
    assign bus.imem_addr   = fetch_pc_r;
    assign bus.instr_valid = (cnt_r != {CNT_W{1'b0}});
    assign bus.instr       = fifo_instr_r[rd_ptr_r];
    assign bus.instr_pc    = fifo_pc_r[rd_ptr_r];

endmodule

// File: tb/tb_ifu_prefetch.sv
// Randomised bench for ifu_prefetch: in-order variable-latency memory model,
// expected-instruction scoreboard and a decoupled decode-side monitor.
module tb_ifu_prefetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] EXC_VEC  = 32'h0000_0080;
    localparam int          DEPTH    = 4;
    localparam int          MAX_OUT  = 2;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } pend_t;

    logic clk;
    logic rst_n;
    ifu_prefetch_if bus ();

    ifu_prefetch #(
        .RESET_PC(RESET_PC), .EXC_VECTOR(EXC_VEC),
        .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAX_OUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.master)
    );

    pend_t       pend[$];
    logic [31:0] exp_q[$];
    logic [31:0] exp_fetch;
    logic [31:0] redir_tgt;
    bit          after_redir;
    int          last_due;
    int          cyc;
    int          checks;
    int          errors;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A3C_0F0F;
    endfunction

    function automatic logic [31:0] ref_target(input logic [1:0] m, input logic [31:0] pc,
                                               input logic [15:0] imm, input logic [25:0] a26,
                                               input logic [31:0] tgt);
        logic [31:0] base;
        int          off;
        base = pc + 32'd4;
        off  = int'($signed(imm));
        case (m)
            2'd0:    return (base & 32'hF000_0000) | (32'(a26) << 2);
            2'd1:    return base + 32'(off * 4);
            2'd2:    return (tgt >> 2) << 2;
            default: return EXC_VEC;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive at the falling edge, check 1 time unit later, advance the model.
    task automatic step(input bit redir, input logic [1:0] mode, input logic [31:0] rpc,
                        input logic [15:0] imm, input logic [25:0] a26, input logic [31:0] tgt,
                        input bit iready, input bit mready, input int lmin, input int lmax);
        pend_t       e;
        bit          resp;
        int          inflight;
        int          due;
        logic [31:0] tgt_v;
        resp = 1'b0;
        e    = '{addr: 32'h0, due: 0, stale: 1'b0};
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            e    = pend.pop_front();
            resp = 1'b1;
        end
        inflight = pend.size() + (resp ? 1 : 0);
        bus.imem_rvalid     = resp;
        bus.imem_rdata      = resp ? word_of(e.addr) : $urandom();
        bus.imem_ready      = mready;
        bus.instr_ready     = iready;
        bus.redirect_valid  = redir;
        bus.redirect_mode   = mode;
        bus.redirect_pc     = rpc;
        bus.redirect_imm16  = imm;
        bus.redirect_addr26 = a26;
        bus.redirect_target = tgt;
        #1;
        chk("imem_req", 32'(bus.imem_req),
            32'((!redir && inflight < MAX_OUT && (exp_q.size() + inflight) < DEPTH) ? 1 : 0));
        chk("instr_valid", 32'(bus.instr_valid), 32'((exp_q.size() > 0) ? 1 : 0));
        if (after_redir) chk("addr_after_redirect", bus.imem_addr, redir_tgt);
        if (bus.imem_req && mready) begin
            chk("imem_addr", bus.imem_addr, exp_fetch);
            due = cyc + int'($urandom_range(lmax, lmin));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pend.push_back('{addr: exp_fetch, due: due, stale: 1'b0});
            exp_fetch = exp_fetch + 32'd4;
        end
        if (resp && !e.stale && !redir) exp_q.push_back(e.addr);
        after_redir = 1'b0;
        if (redir) begin
            tgt_v = ref_target(mode, rpc, imm, a26, tgt);
            exp_q.delete();
            foreach (pend[i]) pend[i].stale = 1'b1;
            exp_fetch   = tgt_v;
            redir_tgt   = tgt_v;
            after_redir = 1'b1;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n, input int mpct, input int lmin, input int lmax,
                       input int ipct, input int rpct);
        for (int k = 0; k < n; k++) begin
            step(int'($urandom_range(99, 0)) < rpct, 2'($urandom_range(3, 0)), $urandom(),
                 16'($urandom()), 26'($urandom()), $urandom(),
                 int'($urandom_range(99, 0)) < ipct, int'($urandom_range(99, 0)) < mpct,
                 lmin, lmax);
        end
    endtask

    task automatic redirect(input logic [1:0] mode, input logic [31:0] rpc, input logic [15:0] imm,
                            input logic [25:0] a26, input logic [31:0] tgt, input int lat);
        step(1'b1, mode, rpc, imm, a26, tgt, 1'b1, 1'b1, lat, lat);
    endtask

    // Called at a falling edge; holds reset for two cycles and releases it at a falling edge.
    task automatic pulse_reset();
        rst_n              = 1'b0;
        bus.imem_rvalid    = 1'b0;
        bus.imem_ready     = 1'b0;
        bus.instr_ready    = 1'b0;
        bus.redirect_valid = 1'b0;
        #1;
        chk("reset_instr_valid", 32'(bus.instr_valid), 32'h0);
        chk("reset_imem_req", 32'(bus.imem_req), 32'h0);
        pend.delete();
        exp_q.delete();
        exp_fetch   = RESET_PC;
        last_due    = -1;
        after_redir = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Decode-side monitor: every consumed word must be the oldest expected one.
    initial begin
        logic [31:0] e_pc;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && bus.instr_valid && bus.instr_ready && !bus.redirect_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_instr: got pc %h expected no word (cycle %0d)",
                             bus.instr_pc, cyc);
                end else begin
                    e_pc = exp_q.pop_front();
                    chk("instr_pc", bus.instr_pc, e_pc);
                    chk("instr", bus.instr, word_of(e_pc));
                end
            end
        end
    end

    initial begin
        checks              = 0;
        errors              = 0;
        cyc                 = 0;
        last_due            = -1;
        after_redir         = 1'b0;
        exp_fetch           = RESET_PC;
        redir_tgt           = 32'h0;
        rst_n               = 1'b0;
        bus.imem_ready      = 1'b0;
        bus.imem_rvalid     = 1'b0;
        bus.imem_rdata      = 32'h0;
        bus.instr_ready     = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_mode   = 2'b00;
        bus.redirect_pc     = 32'h0;
        bus.redirect_imm16  = 16'h0;
        bus.redirect_addr26 = 26'h0;
        bus.redirect_target = 32'h0;
        @(negedge clk);
        pulse_reset();
        run(12, 100, 1, 1, 100, 0);
        run(14, 100, 1, 1, 0, 0);
        run(10, 100, 1, 1, 100, 0);
        redirect(2'd0, 32'h1000_0008, 16'h0000, 26'h000_0002, 32'h0, 1);
        run(6, 100, 1, 1, 100, 0);
        redirect(2'd1, 32'h0000_0010, 16'hFFFE, 26'h0, 32'h0, 1);
        run(6, 100, 1, 1, 100, 0);
        redirect(2'd2, 32'h0, 16'h0, 26'h0, 32'h0000_0047, 1);
        run(6, 100, 1, 1, 100, 0);
        redirect(2'd3, 32'h0000_0400, 16'h0, 26'h0, 32'h0, 1);
        run(6, 100, 1, 1, 100, 0);
        redirect(2'd2, 32'h0, 16'h0, 26'h0, 32'hFFFF_FFF8, 1);
        run(8, 100, 1, 1, 100, 0);
        run(6, 100, 3, 3, 100, 0);
        redirect(2'd0, 32'h0000_0100, 16'h0, 26'h000_0040, 32'h0, 3);
        run(14, 100, 3, 3, 100, 0);
        run(300, 70, 1, 4, 60, 5);
        run(4, 100, 3, 3, 0, 0);
        pulse_reset();
        run(12, 100, 1, 1, 100, 0);
        run(400, 50, 1, 3, 50, 8);
        run(40, 100, 1, 2, 100, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
